// File: rtl/si_tx_arbiter.sv
// Purpose: round-robin arbiter sharing the FT245 simple-interface TX byte channel among N_SRC requesters.
// Latency: 1 cycle from src_rdy to tx_rdy_si; data/rdy/ack paths through a grant are combinational.
// Backpressure: tx_ack_si gates every src_ack; a grant releases after MAX_BURST transfers or when its source drops rdy.
// Optional: define SI_ARB_HEADER_EN to emit a {HDR_TAG, source id} header byte at the start of each grant.
module si_tx_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         MAX_BURST = 64,
    parameter logic [3:0] HDR_TAG   = 4'hA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*N_SRC-1:0]       src_data,
    input  logic [N_SRC-1:0]         src_rdy,
    output logic [N_SRC-1:0]         src_ack,
    output logic [7:0]               tx_data_si,
    output logic                     tx_rdy_si,
    input  logic                     tx_ack_si,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy
);

    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(MAX_BURST + 1);

    // The header id field is 4 bits wide, which bounds the number of sources.
    if (N_SRC < 2 || N_SRC > 16 || MAX_BURST < 1 || $bits(HDR_TAG) != 4) begin : g_bad_param
        $error("si_tx_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_HEADER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    logic [GW-1:0]   cand;
    logic            sel_rdy;
    logic [7:0]      sel_data;
    logic            xfer;

    // Granted source's byte and valid; part-select index is exactly wide enough for 8*N_SRC bits.
    assign sel_rdy  = src_rdy[grant_id_q];
    assign sel_data = src_data[{grant_id_q, 3'b000} +: 8];

    // Search upward from the source after the last grant, wrapping N_SRC-1 -> 0 explicitly.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        cand      = last_grant_q;
        for (int k = 0; k < N_SRC; k++) begin
            cand = (cand == GW'(N_SRC - 1)) ? '0 : cand + 1'b1;
            if (!arb_found && src_rdy[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Sink-facing outputs follow the state directly so reset drops them without a clock edge.
    always_comb begin
        tx_rdy_si  = 1'b0;
        tx_data_si = 8'h00;
        case (state_q)
            ST_GRANT: begin
                tx_rdy_si  = sel_rdy;
                tx_data_si = sel_data;
            end
`ifdef SI_ARB_HEADER_EN
            ST_HEADER: begin
                tx_rdy_si  = 1'b1;
                tx_data_si = {HDR_TAG, 4'(grant_id_q)};
            end
`endif
            default: begin
                tx_rdy_si  = 1'b0;
                tx_data_si = 8'h00;
            end
        endcase
    end

    // A source byte moves only while granted and the sink accepts it.
    assign xfer = tx_rdy_si & tx_ack_si & (state_q == ST_GRANT);

    // Fan the accept pulse back to the granted source only.
    always_comb begin
        src_ack = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ack[i] = xfer & (grant_id_q == GW'(i));
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q != ST_IDLE);

    // Next-state: arbitrate in idle, count transfers in grant, release on burst limit or source stall.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_id_d   = arb_idx;
                    last_grant_d = arb_idx;
                    cnt_d        = '0;
`ifdef SI_ARB_HEADER_EN
                    state_d      = ST_HEADER;
`else
                    state_d      = ST_GRANT;
`endif
                end
            end
`ifdef SI_ARB_HEADER_EN
            // Header byte completes even if the source has dropped rdy; grant then releases at once.
            ST_HEADER: begin
                if (tx_ack_si) begin
                    state_d = ST_GRANT;
                end
            end
`endif
            ST_GRANT: begin
                if (!sel_rdy) begin
                    state_d = ST_IDLE;
                end else if (tx_ack_si) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CW'(MAX_BURST)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last grant resets to N_SRC-1 so source 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(N_SRC - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_si_tx_arbiter.sv
// Bench for si_tx_arbiter: instance 0 uses MAX_BURST=64, instance 1 uses MAX_BURST=4.
// Each source is a counting byte stream that advances on its own src_ack.
// Observed vector per cycle is {tx_rdy_si, busy, grant_id, src_ack, tx_data_si}.
module tb_si_tx_arbiter;

`ifdef SI_ARB_HEADER_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] src_data  [2];
    logic [3:0]  src_rdy   [2];
    logic        tx_ack    [2];
    logic [3:0]  src_ack_w [2];
    logic [7:0]  tx_data_w [2];
    logic        tx_rdy_w  [2];
    logic [1:0]  gid_w     [2];
    logic        busy_w    [2];

    int          cnt  [2][4];
    int          lim  [2][4];
    logic [7:0]  base [2][4];
    logic [3:0]  ack_last [2];

    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    si_tx_arbiter #(.N_SRC(4), .MAX_BURST(64), .HDR_TAG(4'hA)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data[0]),
        .src_rdy    (src_rdy[0]),
        .src_ack    (src_ack_w[0]),
        .tx_data_si (tx_data_w[0]),
        .tx_rdy_si  (tx_rdy_w[0]),
        .tx_ack_si  (tx_ack[0]),
        .grant_id   (gid_w[0]),
        .busy       (busy_w[0])
    );

    si_tx_arbiter #(.N_SRC(4), .MAX_BURST(4), .HDR_TAG(4'hA)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data[1]),
        .src_rdy    (src_rdy[1]),
        .src_ack    (src_ack_w[1]),
        .tx_data_si (tx_data_w[1]),
        .tx_rdy_si  (tx_rdy_w[1]),
        .tx_ack_si  (tx_ack[1]),
        .grant_id   (gid_w[1]),
        .busy       (busy_w[1])
    );

    function automatic logic [15:0] obs(input int u);
        return {tx_rdy_w[u], busy_w[u], gid_w[u], src_ack_w[u], tx_data_w[u]};
    endfunction

    function automatic logic [15:0] mk(input logic r, input logic b, input int g,
                                       input logic [3:0] a, input int d);
        return {r, b, 2'(g), a, 8'(d)};
    endfunction

    task automatic clear(input int u);
        for (int i = 0; i < 4; i++) begin
            cnt[u][i]  = 0;
            lim[u][i]  = 0;
            base[u][i] = 8'h00;
        end
        ack_last[u] = 4'b0000;
    endtask

    task automatic drive(input int u);
        for (int i = 0; i < 4; i++) begin
            src_data[u][8*i +: 8] = base[u][i] + 8'(cnt[u][i]);
            src_rdy[u][i]         = (cnt[u][i] < lim[u][i]);
        end
    endtask

    // One cycle: consume bytes accepted last cycle, drive new inputs at negedge, settle.
    task automatic step(input int u, input logic ack);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (ack_last[u][i]) cnt[u][i]++;
        end
        tx_ack[u] = ack;
        drive(u);
        #1;
        ack_last[u] = src_ack_w[u];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            clear(u);
            tx_ack[u] = 1'b0;
            drive(u);
        end
        repeat (3) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            n_chk++;
            if (obs(u) !== 16'h0000) $display("FAIL reset_hold u=%0d got=%h exp=%h", u, obs(u), 16'h0000);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(0, 1'b0);
            for (int u = 0; u < 2; u++) begin
                n_chk++;
                if (obs(u) !== 16'h0000) $display("FAIL reset_idle u=%0d c=%0d got=%h exp=%h", u, c, obs(u), 16'h0000);
                else n_pass++;
            end
        end
    endtask

    // Source 1 alone, 100 bytes, burst limit 64: one idle cycle splits the stream.
    task automatic test_single_burst();
        logic [15:0] e;
        clear(0);
        lim[0][1] = 100;
        for (int c = 0; c <= 103; c++) begin
            step(0, 1'b1);
            if (c == 0)                 e = mk(0, 0, 0, 4'b0000, 0);
            else if (c == 65 || c == 103) e = mk(0, 0, 1, 4'b0000, 0);
            else if (c == 102)          e = mk(0, 1, 1, 4'b0000, 8'h64);
            else if (c < 65)            e = mk(1, 1, 1, 4'b0010, c - 1);
            else                        e = mk(1, 1, 1, 4'b0010, c - 2);
            n_chk++;
            if (obs(0) !== e) $display("FAIL single c=%0d got=%h exp=%h", c, obs(0), e);
            else n_pass++;
        end
    endtask

    // All four requesting with burst 4: grants 0,1,2,3,0 separated by one idle cycle.
    task automatic test_round_robin();
        logic [15:0] e;
        int g, p, s;
        clear(1);
        for (int i = 0; i < 4; i++) begin
            lim[1][i]  = 8;
            base[1][i] = 8'(16 * i);
        end
        for (int c = 0; c < 25; c++) begin
            step(1, 1'b1);
            g = c / 5;
            p = c % 5;
            if (p == 0) begin
                e = mk(0, 0, (g == 0) ? 0 : (g - 1) % 4, 4'b0000, 0);
            end else begin
                s = g % 4;
                e = mk(1, 1, s, 4'b0001 << s, 16 * s + (g / 4) * 4 + p - 1);
            end
            n_chk++;
            if (obs(1) !== e) $display("FAIL rr c=%0d got=%h exp=%h", c, obs(1), e);
            else n_pass++;
        end
    endtask

    // Source 2 stalls after 3 bytes while source 0 waits; next grant wraps to 0.
    task automatic test_stall();
        logic [15:0] e;
        clear(1);
        lim[1][2]  = 3;
        base[1][2] = 8'h20;
        for (int c = 0; c <= 8; c++) begin
            if (c == 1) lim[1][0] = 1;
            step(1, 1'b1);
            case (c)
                0:       e = mk(0, 0, 0, 4'b0000, 0);
                1, 2, 3: e = mk(1, 1, 2, 4'b0100, 8'h20 + c - 1);
                4:       e = mk(0, 1, 2, 4'b0000, 8'h23);
                5:       e = mk(0, 0, 2, 4'b0000, 0);
                6:       e = mk(1, 1, 0, 4'b0001, 8'h00);
                7:       e = mk(0, 1, 0, 4'b0000, 8'h01);
                default: e = mk(0, 0, 0, 4'b0000, 0);
            endcase
            n_chk++;
            if (obs(1) !== e) $display("FAIL stall c=%0d got=%h exp=%h", c, obs(1), e);
            else n_pass++;
        end
    endtask

    // Sink accepts every 5th cycle: burst of 4 spans 4 transfers, not 4 cycles.
    task automatic test_backpressure();
        logic [15:0] e;
        logic ack;
        clear(1);
        lim[1][1]  = 6;
        base[1][1] = 8'h10;
        for (int c = 0; c <= 30; c++) begin
            ack = (c % 5 == 4);
            step(1, ack);
            if (c == 0)       e = mk(0, 0, 0, 4'b0000, 0);
            else if (c == 20) e = mk(0, 0, 1, 4'b0000, 0);
            else if (c == 30) e = mk(0, 1, 1, 4'b0000, 8'h16);
            else              e = mk(1, 1, 1, ack ? 4'b0010 : 4'b0000, 8'h10 + c / 5);
            n_chk++;
            if (obs(1) !== e) $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs(1), e);
            else n_pass++;
        end
    endtask

    // Source 3 grant (header byte first when enabled), then async reset mid-burst.
    task automatic test_header_and_async_reset();
        logic [15:0] e;
        clear(0);
        lim[0][3]  = 4;
        base[0][3] = 8'h30;
        for (int c = 0; c <= 2 + HB; c++) begin
            step(0, 1'b1);
            if (c == 0)                 e = mk(0, 0, 1, 4'b0000, 0);
            else if (HB == 1 && c == 1) e = mk(1, 1, 3, 4'b0000, 8'hA3);
            else                        e = mk(1, 1, 3, 4'b1000, 8'h30 + c - 1 - HB);
            n_chk++;
            if (obs(0) !== e) $display("FAIL header c=%0d got=%h exp=%h", c, obs(0), e);
            else n_pass++;
        end
        #1 rst = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_chk++;
            if (obs(u) !== 16'h0000) $display("FAIL async_rst u=%0d got=%h exp=%h", u, obs(u), 16'h0000);
            else n_pass++;
        end
        clear(0);
        step(0, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(0, 1'b0);
            for (int u = 0; u < 2; u++) begin
                n_chk++;
                if (obs(u) !== 16'h0000) $display("FAIL post_rst u=%0d c=%0d got=%h exp=%h", u, c, obs(u), 16'h0000);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_backpressure();
        test_header_and_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
